// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Bundles the EX/MEM-side inputs and MEM/WB-side outputs of the
//   memory-access stage into a single port.
//   master : pipeline side (drives WBSig, MemRead, MemWrite, Address,
//            WriteData, dstIn; observes Stall and the MEM/WB register).
//   slave  : the memory-access stage itself.
interface mem_access_stage_if;
   logic [1:0]  WBSig;      // [1]=RegWrite, [0]=MemtoReg from EX/MEM
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] Address;    // byte address (ALU result)
   logic [31:0] WriteData;
   logic [4:0]  dstIn;
   logic        Stall;      // combinational hold request toward hazard unit
   logic        RegWrite;
   logic        MemtoReg;
   logic [31:0] ReadData;
   logic [31:0] ALUResOut;
   logic [4:0]  dstOut;

   modport master (
      output WBSig, MemRead, MemWrite, Address, WriteData, dstIn,
      input  Stall, RegWrite, MemtoReg, ReadData, ALUResOut, dstOut
   );

   modport slave (
      input  WBSig, MemRead, MemWrite, Address, WriteData, dstIn,
      output Stall, RegWrite, MemtoReg, ReadData, ALUResOut, dstOut
   );
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of a five-stage MIPS pipeline. Performs data-memory loads and
//   stores against an internal word array with a LATENCY-cycle access time
//   and registers the result into the MEM/WB boundary. While an access is
//   incomplete, Stall is raised so upstream stages and EX/MEM hold.
// Parameters
//   DEPTH_LOG2 : log2 of memory depth in 32-bit words
//   LATENCY    : cycles per memory access (1..7); 1 means no stall
// Ports
//   clk   : pipeline clock, rising edge
//   reset : synchronous, active-high
//   bus   : slave side of mem_access_stage_if (EX/MEM in, MEM/WB out, Stall)
module mem_access_stage #(
   parameter int DEPTH_LOG2 = 8,
   parameter int LATENCY    = 2
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_stage_if.slave bus
);
   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [2:0] LAST_CNT = 3'(LATENCY - 1);
   localparam bit         MULTI    = (LATENCY > 1);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t                state;
   logic [2:0]            cnt;
   logic [31:0]           mem [DEPTH];

   logic                  mem_op;
   logic                  is_load;
   logic                  stall;
   logic                  commit;
   logic [DEPTH_LOG2-1:0] idx;
   logic [31:0]           rd_word;

   logic                  reg_write;
   logic                  memto_reg;
   logic [31:0]           read_data;
   logic [31:0]           alu_res;
   logic [4:0]            dst;

   // A simultaneous read+write request is treated as a store.
   assign mem_op  = bus.MemRead | bus.MemWrite;
   assign is_load = bus.MemRead & ~bus.MemWrite;

   // Byte offset and bits above the word index are dropped, so the address
   // space wraps every 4*DEPTH bytes.
   assign idx     = bus.Address[DEPTH_LOG2+1:2];
   assign rd_word = mem[idx];

   // Stall covers every cycle of an access except the completing one.
   always_comb begin
      stall = 1'b0;
      if (!reset) begin
         if (state == IDLE) stall = mem_op & MULTI;
         else               stall = (cnt != LAST_CNT);
      end
   end

   // A store lands only on its completing edge; reset abandons it.
   assign commit = ~reset & ~stall & bus.MemWrite;

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         reg_write <= 1'b0;
         memto_reg <= 1'b0;
         read_data <= '0;
         alu_res   <= '0;
         dst       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op && MULTI) begin
                  state <= WAIT;
                  cnt   <= 3'd1;
               end
            end
            WAIT: begin
               if (cnt == LAST_CNT) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt   <= cnt + 3'd1;
               end
            end
         endcase

         // MEM/WB boundary: bubble while stalled, otherwise capture.
         if (stall) begin
            reg_write <= 1'b0;
            memto_reg <= 1'b0;
            read_data <= '0;
            alu_res   <= '0;
            dst       <= '0;
         end else begin
            reg_write <= bus.WBSig[1];
            memto_reg <= bus.WBSig[0];
            read_data <= is_load ? rd_word : 32'h0;
            alu_res   <= bus.Address;
            dst       <= bus.dstIn;
         end
      end
   end

   // Data memory is deliberately not cleared by reset.
   always_ff @(posedge clk) begin
      if (commit) mem[idx] <= bus.WriteData;
   end

   assign bus.Stall     = stall;
   assign bus.RegWrite  = reg_write;
   assign bus.MemtoReg  = memto_reg;
   assign bus.ReadData  = read_data;
   assign bus.ALUResOut = alu_res;
   assign bus.dstOut    = dst;
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage MIPS pipeline: consumes the EX/MEM pipeline register outputs, performs data-memory reads and writes against an internal word array with a configurable multi-cycle access latency, and registers the result into the MEM/WB boundary. While an access is in flight it raises a stall toward the hazard unit so the upstream stages and the EX/MEM register hold. Non-memory instructions pass through with single-cycle latency.

## Interface
- DEPTH_LOG2, 8: log2 of data-memory depth in 32-bit words (256 words).
- LATENCY, 2: cycles per memory access, legal range 1..7; 1 means no stall.

- clk  input  1  pipeline clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; one clock, synchronous reset.
- WBSig  input  2  write-back controls from EX/MEM: [1]=RegWrite, [0]=MemtoReg.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- Address  input  32  byte address (ALU result).
- WriteData  input  32  store data.
- dstIn  input  5  destination register number.
- Stall  output  1  combinational; high while an access is incomplete, so upstream and EX/MEM hold.
- RegWrite  output  1  MEM/WB register-write enable.
- MemtoReg  output  1  MEM/WB select: 1 = ReadData, 0 = ALUResOut.
- ReadData  output  32  registered load data.
- ALUResOut  output  32  registered copy of Address.
- dstOut  output  5  registered destination register.

## Operation
- Word index = Address[DEPTH_LOG2+1:2]; Address[1:0] and bits above the index are ignored, so addresses wrap modulo 4*2^DEPTH_LOG2.
- Memory op = MemRead | MemWrite. If both are high, the op is a store; ReadData for that instruction is 0.
- FSM states: IDLE, WAIT. Counter cnt is 3 bits.
  - IDLE, no memory op: Stall=0; MEM/WB loads inputs, ReadData=0.
  - IDLE, memory op, LATENCY=1: Stall=0; access completes this cycle.
  - IDLE, memory op, LATENCY>1: Stall=1; next state WAIT, cnt<=1; MEM/WB loads a bubble.
  - WAIT, cnt<LATENCY-1: Stall=1; cnt<=cnt+1; MEM/WB loads a bubble.
  - WAIT, cnt==LATENCY-1: Stall=0; access completes; next state IDLE, cnt<=0.
- Bubble: RegWrite=0, MemtoReg=0, dstOut=0, ReadData=0, ALUResOut=0.
- Completion edge:
  - Store: mem[index] <= WriteData.
  - Load: ReadData <= mem[index], read asynchronously in the completing cycle.
  - Always: RegWrite, MemtoReg, ALUResOut and dstOut load from WBSig, Address and dstIn.
- Writes commit only on a completion edge and never while reset=1.
- Inputs are held stable by upstream while Stall=1. The block samples them only at the completion edge.
- Back-to-back memory ops: the next op is seen in IDLE in the cycle after completion and starts a fresh count; no extra dead cycle.
- Memory contents are not cleared by reset.

## Timing
- Reset values: state IDLE, cnt 0, RegWrite 0, MemtoReg 0, ReadData 0, ALUResOut 0, dstOut 0. Stall is forced to 0 while reset=1.
- Reset mid-access: the in-flight access is abandoned with no write; the next cycle is IDLE.
- Latency, non-memory op: 1 cycle, EX/MEM to MEM/WB.
- Latency, memory op: LATENCY cycles. Stall is high for exactly LATENCY-1 consecutive cycles starting the cycle the op appears.
- A load followed immediately by a dependent instruction needs no internal forwarding. MEM/WB holds the data one cycle after completion.

## Test plan
- Reset, then WBSig=2'b10, Address=32'h10, dstIn=5 with no memory op: one cycle later RegWrite=1, ALUResOut=32'h10, dstOut=5, Stall never high.
- LATENCY=2, store WriteData=32'hDEADBEEF to Address=32'h40:
  - Stall high for exactly 1 cycle; the MEM/WB bubble has RegWrite=0.
  - A later load from 32'h40 (WBSig=2'b11, dstIn=8) gives ReadData=32'hDEADBEEF, dstOut=8 after 2 cycles.
- LATENCY=4, back-to-back load, store, load: Stall is high 3 cycles per op with exactly one low cycle between ops; the second load returns the stored value.
- Wrap and alignment, DEPTH_LOG2=8:
  - Store 32'h1234 to Address=32'h403; a load from 32'h000 returns 32'h1234.
  - MemRead=MemWrite=1 stores and returns ReadData=0.
- Reset asserted in the second cycle of a LATENCY=3 store to 32'h80 with data 32'hFFFF: no write occurs (mem[32] unchanged), Stall=0 and outputs 0 the next cycle, and the FSM accepts a new op immediately.
